// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0 and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [23:0]           asm_q, asm_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  xfer;
  logic                  last_word;
  logic                  reload_hit;
  logic                  load_start;
  state_t                image_end;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
  logic                  error_q, error_d;
  assign image_end = S_CHECK;
`else
  assign image_end = S_RUN;
`endif

  assign xfer       = in_valid && in_ready;
  assign last_word  = (word_count_q + 16'd1) == len_q;
  assign reload_hit = reload && ((state_q == S_RUN) || (state_q == S_ERROR));
  assign load_start = (state_d == S_LEN_HI) && (state_q != S_LEN_HI);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = ({len_q[15:8], in_data} == 16'd0) ? image_end : S_DATA;
      S_DATA:   if (xfer && (byte_cnt_q == 2'd3) && last_word) state_d = image_end;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  if (xfer) state_d = (in_data == chk_q) ? S_RUN : S_ERROR;
      S_ERROR:  if (reload) state_d = S_LEN_HI;
`endif
      S_RUN:    if (reload) state_d = S_LEN_HI;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: in_ready = 1'b1;
      default:                             in_ready = 1'b0;
    endcase
  end

  // Datapath and registered outputs; reload forces cpu_rst high on the very next cycle
  always_comb begin
    len_d        = len_q;
    asm_d        = asm_q;
    byte_cnt_d   = byte_cnt_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_d    = (state_q != S_RUN) || reload_hit;
    done_d       = (state_q == S_RUN) && !reload_hit;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
    error_d      = (state_q == S_ERROR) && !reload_hit;
`endif
    if (load_start) begin
      word_count_d = 16'd0;
      byte_cnt_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_d        = 8'd0;
`endif
    end
    if (xfer) begin
      case (state_q)
        S_LEN_HI: len_d = {in_data, len_q[7:0]};
        S_LEN_LO: len_d = {len_q[15:8], in_data};
        S_DATA: begin
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            imem_wdata_d = {asm_q, in_data};
            word_count_d = word_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= 16'd0;
      asm_q        <= 24'd0;
      byte_cnt_q   <= 2'd0;
      word_count_q <= 16'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      len_q        <= len_d;
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q   <= 8'd0;
      error_q <= 1'b0;
    end else begin
      chk_q   <= chk_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single loads, back-to-back words, stalls, reload,
// mid-load reset and (with LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_loader #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_n = 0;
  int base;
  logic [15:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  logic [7:0]  xsum;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (imem_we && wr_n < 64) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("send_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    xsum = 8'h00;
    send(n[15:8]);
    send(n[7:0]);
  endtask

  task automatic send_pay(input logic [7:0] b);
    xsum = xsum ^ b;
    send(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_pay(w[8*i +: 8]);
  endtask

  task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
    send(xsum);
`endif
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic expect_release(input string tag);
    check({tag, "_cpu_rst_pre"}, cpu_rst, 1);
    check({tag, "_done_pre"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    tick();
    check({tag, "_cpu_rst_post"}, cpu_rst, 0);
    check({tag, "_done_post"}, done, 1);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_word_count", word_count, 0);
    rst = 1'b0;

    // Single word 0x12345678
    base = wr_n;
    send_len(16'd1);
    send_word(32'h12345678);
    check("t1_we", imem_we, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_wdata", imem_wdata, 32'h12345678);
    send_chk();
    expect_release("t1");
    check("t1_word_count", word_count, 1);
    check("t1_nwrites", wr_n - base, 1);

    // Reload from RUN, rewrite address 0
    pulse_reload();
    check("rl_cpu_rst", cpu_rst, 1);
    check("rl_done", done, 0);
    check("rl_word_count", word_count, 0);
    check("rl_in_ready", in_ready, 1);
    base = wr_n;
    send_len(16'd1);
    send_word(32'hDEADBEEF);
    send_chk();
    expect_release("rl");
    check("rl_nwrites", wr_n - base, 1);
    check("rl_addr", wr_addr[base], 0);
    check("rl_wdata", wr_data[base], 32'hDEADBEEF);

    // Three words back to back
    pulse_reload();
    base = wr_n;
    send_len(16'd3);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    send_chk();
    expect_release("t2");
    check("t2_nwrites", wr_n - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr", wr_addr[base + i], i);
      check("t2_wdata", wr_data[base + i], i + 1);
    end
    check("t2_gap01", wr_cyc[base + 1] - wr_cyc[base], 4);
    check("t2_gap12", wr_cyc[base + 2] - wr_cyc[base + 1], 4);
    check("t2_word_count", word_count, 3);

    // Stall for 5 cycles after the 2nd byte of a word
    pulse_reload();
    base = wr_n;
    send_len(16'd1);
    send_pay(8'hCA);
    send_pay(8'hFE);
    in_data = 8'hFF;
    repeat (5) tick();
    check("t3_gap_writes", wr_n - base, 0);
    check("t3_gap_we", imem_we, 0);
    send_pay(8'hBA);
    send_pay(8'hBE);
    send_chk();
    expect_release("t3");
    check("t3_nwrites", wr_n - base, 1);
    check("t3_wdata", wr_data[base], 32'hCAFEBABE);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: AA^55^0F^F0 = 00
    pulse_reload();
    send_len(16'd1);
    send_word(32'hAA550FF0);
    send(8'h00);
    expect_release("ck_good");
    // Bad checksum
    pulse_reload();
    send_len(16'd1);
    send_word(32'hAA550FF0);
    send(8'h01);
    check("ck_bad_in_ready", in_ready, 0);
    tick();
    check("ck_bad_error", error, 1);
    check("ck_bad_cpu_rst", cpu_rst, 1);
    check("ck_bad_done", done, 0);
    tick();
    check("ck_bad_cpu_rst_held", cpu_rst, 1);
    pulse_reload();
    check("ck_reload_error", error, 0);
    check("ck_reload_in_ready", in_ready, 1);
    send_len(16'd1);
    send_word(32'h0BADF00D);
    send_chk();
    expect_release("ck_recover");
`endif

    // Reset in the middle of the second word
    pulse_reload();
    send_len(16'd2);
    send_word(32'h11111111);
    send_pay(8'h22);
    send_pay(8'h33);
    check("t6_pre_word_count", word_count, 1);
    check("t6_pre_in_ready", in_ready, 1);
    rst = 1'b1;
    #1;
    check("t6_in_ready", in_ready, 0);
    check("t6_cpu_rst", cpu_rst, 1);
    check("t6_done", done, 0);
    check("t6_word_count", word_count, 0);
    check("t6_imem_we", imem_we, 0);
    check("t6_imem_addr", imem_addr, 0);
    check("t6_imem_wdata", imem_wdata, 0);
    tick();
    rst = 1'b0;
    base = wr_n;
    send_len(16'd1);
    send_word(32'hA55A3CC3);
    send_chk();
    expect_release("t6");
    check("t6_nwrites", wr_n - base, 1);
    check("t6_addr", wr_addr[base], 0);
    check("t6_wdata", wr_data[base], 32'hA55A3CC3);
    check("t6_final_count", word_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
